// File: rtl/cordic_iq_scheduler.sv
// Shares one pipelined CORDIC angle unit between two I/Q requesters: round-robin
// grant, operand register, tag pipeline, and per-owner angle / phase-difference result.
module cordic_iq_scheduler #(
  parameter int IQ_W       = 4,
  parameter int ANG_W      = 16,
  parameter int CORDIC_LAT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_req0_valid,
  input  logic [IQ_W-1:0]  i_req0_I,
  input  logic [IQ_W-1:0]  i_req0_Q,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [IQ_W-1:0]  i_req1_I,
  input  logic [IQ_W-1:0]  i_req1_Q,
  output logic             o_req1_ready,
  output logic [IQ_W-1:0]  o_cordic_I,
  output logic [IQ_W-1:0]  o_cordic_Q,
  input  logic [ANG_W-1:0] i_cordic_angle,
  output logic             o_res_valid,
  output logic             o_res_id,
  output logic [ANG_W-1:0] o_res_angle,
  output logic [ANG_W-1:0] o_res_dangle,
  output logic             o_res_first
);

  localparam int DEPTH = CORDIC_LAT + 1;

  logic             clr;
  logic             gnt0;
  logic             gnt1;
  logic             xfer;
  logic             xfer_id;

  logic             last_id_q, last_id_d;
  logic [IQ_W-1:0]  cordic_i_q, cordic_i_d;
  logic [IQ_W-1:0]  cordic_q_q, cordic_q_d;

  logic [DEPTH-1:0] tag_valid_q, tag_valid_d;
  logic [DEPTH-1:0] tag_id_q, tag_id_d;
  logic             exit_valid;
  logic             exit_id;

  logic             hit [2];
  logic             have_prev_q [2];
  logic             have_prev_d [2];
  logic [ANG_W-1:0] prev_q [2];
  logic [ANG_W-1:0] prev_d [2];

  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic [ANG_W-1:0] res_angle_q, res_angle_d;
  logic [ANG_W-1:0] res_dangle_q, res_dangle_d;
  logic             res_first_q, res_first_d;

  assign clr = reset | i_flush;

  // last_id_q = 1 after reset/flush, so requester 0 wins the first tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!clr) begin
      if (i_req0_valid && i_req1_valid) begin
        gnt0 = last_id_q;
        gnt1 = ~last_id_q;
      end else begin
        gnt0 = i_req0_valid;
        gnt1 = i_req1_valid;
      end
    end
  end

  assign xfer         = gnt0 | gnt1;
  assign xfer_id      = gnt1;
  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;

  always_comb begin
    last_id_d  = last_id_q;
    cordic_i_d = cordic_i_q;
    cordic_q_d = cordic_q_q;
    if (i_flush) begin
      last_id_d = 1'b1;
    end else if (xfer) begin
      last_id_d = xfer_id;
    end
    if (gnt1) begin
      cordic_i_d = i_req1_I;
      cordic_q_d = i_req1_Q;
    end else if (gnt0) begin
      cordic_i_d = i_req0_I;
      cordic_q_d = i_req0_Q;
    end
  end

  // Stage j holds the tag whose operand loaded j+1 edges ago; stage CORDIC_LAT
  // therefore lines up with the CORDIC output for that operand.
  assign tag_valid_d[0] = xfer;
  assign tag_id_d[0]    = xfer_id;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_tag
      assign tag_valid_d[gi] = tag_valid_q[gi-1] & ~clr;
      assign tag_id_d[gi]    = tag_id_q[gi-1];
    end
  endgenerate

  assign exit_valid = tag_valid_q[CORDIC_LAT];
  assign exit_id    = tag_id_q[CORDIC_LAT];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hist
      assign hit[gi]         = exit_valid && !clr && (exit_id == 1'(gi));
      assign have_prev_d[gi] = i_flush ? 1'b0 : (have_prev_q[gi] | hit[gi]);
      assign prev_d[gi]      = hit[gi] ? i_cordic_angle : prev_q[gi];

      always_ff @(posedge clock) begin
        if (reset) begin
          have_prev_q[gi] <= 1'b0;
          prev_q[gi]      <= '0;
        end else begin
          have_prev_q[gi] <= have_prev_d[gi];
          prev_q[gi]      <= prev_d[gi];
        end
      end
    end
  endgenerate

  // Difference is plain modular subtraction; the consumer reads it as signed.
  always_comb begin
    res_valid_d  = exit_valid & ~clr;
    res_id_d     = res_id_q;
    res_angle_d  = res_angle_q;
    res_dangle_d = res_dangle_q;
    res_first_d  = res_first_q;
    if (exit_valid && !clr) begin
      res_id_d     = exit_id;
      res_angle_d  = i_cordic_angle;
      res_first_d  = ~have_prev_q[exit_id];
      res_dangle_d = have_prev_q[exit_id] ? (i_cordic_angle - prev_q[exit_id]) : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_id_q    <= 1'b1;
      cordic_i_q   <= '0;
      cordic_q_q   <= '0;
      tag_valid_q  <= '0;
      tag_id_q     <= '0;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      res_angle_q  <= '0;
      res_dangle_q <= '0;
      res_first_q  <= 1'b0;
    end else begin
      last_id_q    <= last_id_d;
      cordic_i_q   <= cordic_i_d;
      cordic_q_q   <= cordic_q_d;
      tag_valid_q  <= tag_valid_d;
      tag_id_q     <= tag_id_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_angle_q  <= res_angle_d;
      res_dangle_q <= res_dangle_d;
      res_first_q  <= res_first_d;
    end
  end

  assign o_cordic_I   = cordic_i_q;
  assign o_cordic_Q   = cordic_q_q;
  assign o_res_valid  = res_valid_q;
  assign o_res_id     = res_id_q;
  assign o_res_angle  = res_angle_q;
  assign o_res_dangle = res_dangle_q;
  assign o_res_first  = res_first_q;

endmodule
